// File: rtl/riscy_pkg.sv
// ============================================================================
//  Module      : riscy_pkg
//  Description : Shared types and constants for the instruction read responder
//                (NOP encoding, fill FSM states, line buffer entry layout).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscy_pkg;

    // Two RISC-V NOPs (addi x0,x0,0) packed into one 64-bit fetch word
    localparam logic [63:0] INSTR_NOP = 64'h0000_0013_0000_0013;

    // Tag field is sized for the widest possible bus; narrower buses
    // zero-extend their tag so the compare stays uniform.
    localparam int IBUF_TAG_W = 62;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        WR   = 2'd3
    } resp_state_t;

    typedef struct packed {
        logic                  valid;
        logic [IBUF_TAG_W-1:0] tag;
        logic [63:0]           data;
    } ibuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_line_buffer.sv
// ============================================================================
//  Module      : instr_line_buffer
//  Description : Two-entry tagged instruction line buffer with LRU victim
//                selection, most-recently-filled priority and bulk invalidate.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_line_buffer
    import riscy_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_en,
    input  logic [IBUF_TAG_W-1:0] lookup_tag,
    output logic                  hit,
    output logic [63:0]           hit_data,
    input  logic                  wr_en,
    input  logic [IBUF_TAG_W-1:0] wr_tag,
    input  logic [63:0]           wr_data,
    input  logic                  invalidate
);

    ibuf_entry_t [1:0] entry_q;
    ibuf_entry_t [1:0] entry_d;
    logic              lru_q;
    logic              lru_d;
    logic              mrf_q;
    logic              mrf_d;
    logic [1:0]        match;
    logic              hit_idx;
    logic              victim;

    // Tag compare; a double hit (same line fetched twice) resolves to the newer fill
    always_comb begin
        match[0] = entry_q[0].valid && (entry_q[0].tag == lookup_tag);
        match[1] = entry_q[1].valid && (entry_q[1].tag == lookup_tag);
        hit      = |match;
        hit_idx  = (&match) ? mrf_q : match[1];
        hit_data = entry_q[hit_idx].data;
        victim   = !entry_q[0].valid ? 1'b0 :
                   !entry_q[1].valid ? 1'b1 : lru_q;
    end

    // Next buffer contents: hits refresh LRU, fills override, invalidate overrides all
    always_comb begin
        entry_d = entry_q;
        lru_d   = lru_q;
        mrf_d   = mrf_q;
        if (lookup_en && hit) begin
            lru_d = ~hit_idx;
        end
        if (wr_en) begin
            entry_d[victim].valid = 1'b1;
            entry_d[victim].tag   = wr_tag;
            entry_d[victim].data  = wr_data;
            lru_d                 = ~victim;
            mrf_d                 = victim;
        end
        if (invalidate) begin
            entry_d[0].valid = 1'b0;
            entry_d[1].valid = 1'b0;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            lru_q   <= 1'b0;
            mrf_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            lru_q   <= lru_d;
            mrf_q   <= mrf_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_read_responder.sv
// ============================================================================
//  Module      : instr_read_responder
//  Description : Fetch-side instruction read responder. Serves 64-bit reads
//                from a 2-entry line buffer, fills misses as two 32-bit bus
//                beats and optionally prefetches the next sequential line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_read_responder
    import riscy_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_read_in,
    input  logic [63:0]       instr_address_in,
    input  logic              invalidate_in,
    output logic [63:0]       instr_read_value_out,
    output logic              instr_stall_out,
    output logic              misalign_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ready_in,
    input  logic [31:0]       mem_rdata_in
);

    resp_state_t           state_q;
    resp_state_t           state_d;
    logic [ADDR_W-1:0]     fill_addr_q;
    logic [ADDR_W-1:0]     fill_addr_d;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [31:0]           lo_q;
    logic [31:0]           lo_d;
    logic [31:0]           hi_q;
    logic [31:0]           hi_d;
    logic                  prefetch_q;
    logic                  prefetch_d;
    logic                  kill_q;
    logic                  kill_d;

    logic [ADDR_W-1:0]     req_addr;
    logic [IBUF_TAG_W-1:0] lookup_tag;
    logic [IBUF_TAG_W-1:0] fill_tag;
    logic                  aligned;
    logic                  lookup_en;
    logic                  buf_hit;
    logic [63:0]           buf_data;
    logic                  demand_miss;
    logic                  other_miss;
    logic                  buf_wr_en;

    // Address bits above the bus width never reach the buffer or the bus
    generate
        if (ADDR_W < 64) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^instr_address_in[63:ADDR_W];
        end
    endgenerate

    assign req_addr    = instr_address_in[ADDR_W-1:0];
    assign lookup_tag  = IBUF_TAG_W'(req_addr[ADDR_W-1:2]);
    assign fill_tag    = IBUF_TAG_W'(fill_addr_q[ADDR_W-1:2]);
    assign mem_req_out  = (state_q == LO) || (state_q == HI);
    assign mem_addr_out = mem_addr_q;

    instr_line_buffer u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_en  (lookup_en),
        .lookup_tag (lookup_tag),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .wr_en      (buf_wr_en),
        .wr_tag     (fill_tag),
        .wr_data    ({hi_q, lo_q}),
        .invalidate (invalidate_in)
    );

    // Fetch-side response: hits are zero-latency, misaligned reads never stall
    always_comb begin
        aligned              = (req_addr[1:0] == 2'b00);
        lookup_en            = instr_read_in && aligned;
        misalign_out         = instr_read_in && !aligned;
        demand_miss          = lookup_en && !buf_hit;
        // a miss that the line currently being written will not satisfy
        other_miss           = demand_miss && (lookup_tag != fill_tag);
        instr_stall_out      = demand_miss;
        instr_read_value_out = (lookup_en && buf_hit) ? buf_data : INSTR_NOP;
    end

    // Fill FSM: two beats, then one write cycle; beats are never abandoned
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        mem_addr_d  = mem_addr_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        prefetch_d  = prefetch_q;
        kill_d      = kill_q;
        buf_wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (demand_miss) begin
                    state_d     = LO;
                    fill_addr_d = req_addr;
                    mem_addr_d  = req_addr;
                    prefetch_d  = 1'b0;
                    kill_d      = 1'b0;
                end
            end
            LO: begin
                kill_d = kill_q || invalidate_in;
                if (mem_ready_in) begin
                    lo_d       = mem_rdata_in;
                    mem_addr_d = fill_addr_q + ADDR_W'(4);
                    state_d    = HI;
                end
            end
            HI: begin
                kill_d = kill_q || invalidate_in;
                if (mem_ready_in) begin
                    hi_d    = mem_rdata_in;
                    state_d = WR;
                end
            end
            WR: begin
                buf_wr_en = !kill_q && !invalidate_in;
                state_d   = IDLE;
                if (PREFETCH_EN && buf_wr_en && !prefetch_q && !other_miss) begin
                    state_d     = LO;
                    fill_addr_d = fill_addr_q + ADDR_W'(8);
                    mem_addr_d  = fill_addr_q + ADDR_W'(8);
                    prefetch_d  = 1'b1;
                    kill_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill FSM and bus registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            mem_addr_q  <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            prefetch_q  <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            mem_addr_q  <= mem_addr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            prefetch_q  <= prefetch_d;
            kill_q      <= kill_d;
        end
    end

endmodule

`default_nettype wire
